aes128_encrypt_iterative: RTL and testbench
===========================================

// Module: aes128_encrypt_iterative
// PURPOSE
//  - Iterative AES-128 encryption core (FIPS-197): the transmit-side counterpart of the AES-128 decryption datapath.
//  - Executes one full round per clock, reusing a single round datapath.
//  - Expands round keys on the fly, so no key schedule storage is needed.
//  - Valid/ready handshake on input and output. Ciphertext from this core feeds the decryption block.
// PARAMETERS
//  - NR        10    number of rounds; only 10 is legal for AES-128 (elaboration error otherwise)
//  - RST_STATE 1'b0  value loaded into the data and key registers on reset (all bits)
// PORTS
//  - CLK                  in   1    clock; all state updates on the rising edge
//  - RST_N                in   1    asynchronous active-low reset
//  - IN_VALID             in   1    PLAIN_DATA/CIPHER_KEY valid
//  - IN_READY             out  1    core idle, can accept a block
//  - PLAIN_DATA           in   128  [0:127]; byte0 = bits [0:7]; column-major state
//  - CIPHER_KEY           in   128  [0:127]; same byte ordering
//  - OUT_VALID            out  1    ENCRYPTED_DATA valid
//  - OUT_READY            in   1    downstream accepts ENCRYPTED_DATA
//  - ENCRYPTED_DATA       out  128  [0:127] ciphertext
//  - LAST_ROUND_KEY       out  128  present only under AES_ENC_LAST_KEY_OUT_EN
// BEHAVIOUR
//  - Reset (RST_N=0, asynchronous):
//      - state=IDLE; IN_READY=0, OUT_VALID=0.
//      - ENCRYPTED_DATA, round key register and round counter are cleared.
//      - rcon=8'h01.
//      - IN_READY rises on the first CLK edge after RST_N deassertion.
//  - FSM IDLE -> ROUND -> DONE -> IDLE. IN_READY is registered and equals (state==IDLE).
//  - IDLE, on IN_VALID & IN_READY (accept edge E0):
//      - state_reg <= PLAIN_DATA ^ CIPHER_KEY; key_reg <= CIPHER_KEY.
//      - rnd <= 1; rcon <= 8'h01; IN_READY <= 0; go to ROUND.
//  - ROUND, each edge:
//      - nk = KeyExpand(key_reg, rcon):
//          - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
//          - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
//      - state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ nk; MixColumns is skipped when rnd==NR.
//      - key_reg <= nk; rcon <= xtime(rcon), i.e. 01,02,...,80,1B,36; rnd <= rnd+1.
//  - Round NR completes at edge E10: state_reg holds the ciphertext, OUT_VALID <= 1, go to DONE.
//  - Latency: OUT_VALID is high 10 clocks after the accept edge.
//  - DONE:
//      - ENCRYPTED_DATA and OUT_VALID are held stable until OUT_READY=1.
//      - On that edge: OUT_VALID <= 0, IN_READY <= 1, go to IDLE.
//  - Throughput: minimum 12 clocks per block with OUT_READY tied high.
//  - Boundary conditions:
//      - IN_VALID while not IDLE: ignored; inputs are not sampled and there is no side effect.
//      - PLAIN_DATA/CIPHER_KEY may change after the accept edge without affecting the result.
//      - OUT_READY while OUT_VALID=0: ignored.
//      - RST_N low in any state: immediate return to reset values; the partial block is discarded and no OUT_VALID pulse is produced.
//      - rnd never exceeds NR; the ROUND -> DONE transition is the only exit from ROUND.
//  - SubBytes uses a combinational 256-entry forward S-box (16 copies in state, 4 in key path); no extra pipeline stages.
// CONFIGURATION
//  - AES_ENC_LAST_KEY_OUT_EN defined:
//      - Adds output LAST_ROUND_KEY = key_reg (the round-10 key), valid and stable whenever OUT_VALID=1.
//      - Resets to 0. Used to feed the decryption block's first AddRoundKey.
//  - AES_ENC_LAST_KEY_OUT_EN undefined:
//      - The port does not exist; the key register is unchanged; no other behaviour differs.
// TESTING
//  - FIPS-197 App.B: PT 3243f6a8885a308d313198a2e0370734, K 2b7e151628aed2a6abf7158809cf4f3c
//      -> CT 3925841d02dc09fbdc118597196a0b32, OUT_VALID at E0+10.
//  - FIPS-197 App.C.1: PT 00112233445566778899aabbccddeeff, K 000102030405060708090a0b0c0d0e0f
//      -> CT 69c4e0d86a7b0430d8cdb78070b4c55a.
//      - With AES_ENC_LAST_KEY_OUT_EN: LAST_ROUND_KEY=13111d7fe3944a17f307a78b4d2b30c5.
//  - Backpressure: hold OUT_READY=0 for 20 clocks after OUT_VALID
//      -> ENCRYPTED_DATA stable, IN_READY=0 throughout, single handshake on release.
//  - Busy input: toggle IN_VALID with random data during ROUND
//      -> result still equals the App.B CT; next accept only after the DONE->IDLE transition.
//  - Reset mid-op: drop RST_N at E0+5
//      -> outputs zero immediately; after release IN_READY=1 next edge; the App.C.1 vector then passes.
//  - Back-to-back, OUT_READY=1, 100 random blocks
//      -> 12-clock period; each CT matches the reference model; round-trip through the decryption block returns PT.

Source files
------------

// File: rtl/aes128_encrypt_iterative_if.sv
// Valid/ready bundle for aes128_encrypt_iterative. Byte 0 of each 128-bit word is bits [127:120].
// With AES_ENC_LAST_KEY_OUT_EN defined, the bundle also carries last_round_key.
interface aes128_encrypt_iterative_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_data;
  logic [127:0] cipher_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] encrypted_data;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0] last_round_key;

  modport master (
    output in_valid, plain_data, cipher_key, out_ready,
    input  in_ready, out_valid, encrypted_data, last_round_key
  );
  modport slave (
    input  in_valid, plain_data, cipher_key, out_ready,
    output in_ready, out_valid, encrypted_data, last_round_key
  );
`else
  modport master (
    output in_valid, plain_data, cipher_key, out_ready,
    input  in_ready, out_valid, encrypted_data
  );
  modport slave (
    input  in_valid, plain_data, cipher_key, out_ready,
    output in_ready, out_valid, encrypted_data
  );
`endif
endinterface

// File: rtl/aes128_encrypt_iterative.sv
// Iterative AES-128 encryption: one round per clock, round keys expanded on the fly.
// Optional AES_ENC_LAST_KEY_OUT_EN exposes the round-10 key as last_round_key.
module aes128_encrypt_iterative #(
  parameter int unsigned NR        = 10,
  parameter logic        RST_STATE = 1'b0
) (
  input logic                       clk_i,
  input logic                       rst_n_i,
  aes128_encrypt_iterative_if.slave aes_io
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_encrypt_iterative: NR must be 10 for AES-128");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Forward S-box, entry 0 in the most significant byte, so sbox(b) = SBOX[~b].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  // Column-major state: byte index = row + 4*col; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] next_key;
  logic [127:0] sr_state;
  logic [127:0] round_out;
  logic         last_round;

  always_comb begin
    next_key   = key_expand(key_q, rcon_q);
    sr_state   = shift_rows(sub_bytes(data_q));
    last_round = (rnd_q == 4'(NR));
    round_out  = (last_round ? sr_state : mix_columns(sr_state)) ^ next_key;
  end

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    fsm_d  = fsm_q;
    data_d = data_q;
    key_d  = key_q;
    rcon_d = rcon_q;
    rnd_d  = rnd_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (aes_io.in_valid && in_ready_q) begin
          data_d = aes_io.plain_data ^ aes_io.cipher_key;
          key_d  = aes_io.cipher_key;
          rcon_d = 8'h01;
          rnd_d  = 4'd1;
          fsm_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        data_d = round_out;
        key_d  = next_key;
        if (last_round) begin
          fsm_d = ST_DONE;
        end else begin
          rcon_d = xtime(rcon_q);
          rnd_d  = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (aes_io.out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    // Handshake flags are registered copies of the next state.
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q       <= ST_IDLE;
      data_q      <= {128{RST_STATE}};
      key_q       <= {128{RST_STATE}};
      rcon_q      <= 8'h01;
      rnd_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      fsm_q       <= fsm_d;
      data_q      <= data_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign aes_io.in_ready       = in_ready_q;
  assign aes_io.out_valid      = out_valid_q;
  assign aes_io.encrypted_data = data_q;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  assign aes_io.last_round_key = key_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iterative.sv
// Directed and back-to-back bench for aes128_encrypt_iterative, with an independent
// reference cipher/inverse cipher built from GF(2^8) arithmetic.
module tb_aes128_encrypt_iterative;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  aes128_encrypt_iterative_if bus ();

  aes128_encrypt_iterative dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .aes_io (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [10:0][127:0] expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [10:0][127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [10:0][127:0] rk;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] v;
    rk = expand_key(key);
    v  = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[4*c + rr] = (r == 10) ? t[4*c + rr] :
                        gmul(t[4*c + rr], 8'h02) ^ gmul(t[4*c + (rr+1)%4], 8'h03) ^
                        t[4*c + (rr+2)%4] ^ t[4*c + (rr+3)%4];
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
      v = v ^ rk[r];
    end
    return v;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [10:0][127:0] rk;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] v;
    rk = expand_key(key);
    v  = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) s[i] = v[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = isb[s[rr + 4*((c - rr + 4) % 4)]];
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = t[i];
      v = v ^ rk[r];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) t[i] = v[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++)
            s[4*c + rr] = gmul(t[4*c + rr], 8'h0e) ^ gmul(t[4*c + (rr+1)%4], 8'h0b) ^
                          gmul(t[4*c + (rr+2)%4], 8'h0d) ^ gmul(t[4*c + (rr+3)%4], 8'h09);
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
      end
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one block for exactly one accept edge.
  task automatic accept_block(input string name, input logic [127:0] pt, input logic [127:0] key);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_timeout: in_ready=%b required 1", name, bus.in_ready);
    end
    bus.in_valid   = 1'b1;
    bus.plain_data = pt;
    bus.cipher_key = key;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.encrypted_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b data=%h required 0 0 0",
               bus.in_ready, bus.out_valid, bus.encrypted_data);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge: in_ready=%b required 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_model_self();
    checks++;
    if (aes_enc(PT_B, K_B) !== CT_B) begin
      failures++;
      $display("FAIL model_app_b: got %h required %h", aes_enc(PT_B, K_B), CT_B);
    end
  endtask

  task automatic test_app_b();
    int lat;
    accept_block("app_b", PT_B, K_B);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL app_b_ready_drop: in_ready=%b required 0", bus.in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL app_b_latency: got %0d required 10", lat);
    end
    checks++;
    if (bus.encrypted_data !== CT_B) begin
      failures++;
      $display("FAIL app_b_ct: got %h required %h", bus.encrypted_data, CT_B);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL app_b_handshake: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_app_c1();
    int lat;
    accept_block("app_c1", PT_C, K_C);
    bus.plain_data = ~PT_C;
    bus.cipher_key = ~K_C;
    wait_out(lat);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.encrypted_data !== CT_C) begin
      failures++;
      $display("FAIL app_c1_ct: valid=%b got %h required %h", bus.out_valid, bus.encrypted_data, CT_C);
    end
`ifdef AES_ENC_LAST_KEY_OUT_EN
    checks++;
    if (bus.last_round_key !== LK_C) begin
      failures++;
      $display("FAIL app_c1_last_key: got %h required %h", bus.last_round_key, LK_C);
    end
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    accept_block("bp", PT_B, K_B);
    wait_out(lat);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.encrypted_data !== CT_B) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b data=%h required 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.encrypted_data, CT_B);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_handshake: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_busy_input();
    int lat;
    bit ready_leak;
    ready_leak = 1'b0;
    accept_block("busy", PT_B, K_B);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      bus.in_valid   = 1'($urandom_range(1));
      bus.plain_data = {$urandom, $urandom, $urandom, $urandom};
      bus.cipher_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
      if (bus.in_ready !== 1'b0) ready_leak = 1'b1;
    end
    checks++;
    if (lat != 10 || ready_leak) begin
      failures++;
      $display("FAIL busy_timing: latency=%0d ready_leak=%b required 10 0", lat, ready_leak);
    end
    checks++;
    if (bus.encrypted_data !== CT_B) begin
      failures++;
      $display("FAIL busy_ct: got %h required %h", bus.encrypted_data, CT_B);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_no_early_accept: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    accept_block("mid", PT_B, K_B);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.encrypted_data !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: in_ready=%b out_valid=%b data=%h required 0 0 0",
               bus.in_ready, bus.out_valid, bus.encrypted_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    accept_block("mid_c1", PT_C, K_C);
    wait_out(lat);
    checks++;
    if (lat != 10 || bus.encrypted_data !== CT_C) begin
      failures++;
      $display("FAIL mid_reset_c1: latency=%0d got %h required 10 %h", lat, bus.encrypted_data, CT_C);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [100];
    logic [127:0] keys [100];
    logic [127:0] exp_ct [100];
    int sent, got, last_acc;
    bit acc;
    for (int i = 0; i < 100; i++) begin
      pts[i]    = {$urandom, $urandom, $urandom, $urandom};
      keys[i]   = {$urandom, $urandom, $urandom, $urandom};
      exp_ct[i] = aes_enc(pts[i], keys[i]);
    end
    sent = 0;
    got = 0;
    last_acc = 0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.plain_data = pts[0];
    bus.cipher_key = keys[0];
    for (int cyc = 0; cyc < 1400 && got < 100; cyc++) begin
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        if (sent > 0) begin
          checks++;
          if (cyc - last_acc != 12) begin
            failures++;
            $display("FAIL b2b_period block %0d: got %0d required 12", sent, cyc - last_acc);
          end
        end
        last_acc = cyc;
        sent++;
        if (sent < 100) begin
          bus.plain_data = pts[sent];
          bus.cipher_key = keys[sent];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.encrypted_data !== exp_ct[got]) begin
          failures++;
          $display("FAIL b2b_ct block %0d: got %h required %h", got, bus.encrypted_data, exp_ct[got]);
        end
        checks++;
        if (aes_dec(bus.encrypted_data, keys[got]) !== pts[got]) begin
          failures++;
          $display("FAIL b2b_roundtrip block %0d: got %h required %h",
                   got, aes_dec(bus.encrypted_data, keys[got]), pts[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 100) begin
      failures++;
      $display("FAIL b2b_count: got %0d blocks required 100", got);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.plain_data = '0;
    bus.cipher_key = '0;
    build_sbox();
    test_reset();
    test_model_self();
    test_app_b();
    test_app_c1();
    test_backpressure();
    test_busy_input();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
